// File: rtl/bit_reverse_mapper.sv
// Registered bit-reversal permutation of a packed word vector: out[i] = in[rev(i)].
// The permutation is pure wiring; only the output vector and its valid flag are stored.
module bit_reverse_mapper #(
  parameter int N = 3,
  parameter int W = 32,
  localparam int SIZE = 2 ** N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SIZE-1:0][W-1:0]  in,
  output logic                    out_valid,
  output logic [SIZE-1:0][W-1:0]  out
);

  // Evaluated only on genvar arguments, so every source index is an elaboration constant.
  function automatic int unsigned rev(input int unsigned idx);
    int unsigned r;
    r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx[k]) r[N-1-k] = 1'b1;
    end
    return r;
  endfunction

  logic [SIZE-1:0][W-1:0] mapped;

  for (genvar i = 0; i < SIZE; i++) begin : g_map
    localparam int unsigned SRC = rev(i);
    assign mapped[i] = in[SRC];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= mapped;
    end
  end

endmodule

// File: tb/tb_bit_reverse_mapper.sv
// Scoreboard bench for bit_reverse_mapper: N=3 instance checked every cycle, N=4 instance spot-checked.
module tb_bit_reverse_mapper;
  localparam int W = 32;
  typedef logic [511:0] wide_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic                 iv3;
  logic [7:0][W-1:0]    in3;
  logic                 ov3;
  logic [7:0][W-1:0]    out3;

  logic                 iv4;
  logic [15:0][W-1:0]   in4;
  logic                 ov4;
  logic [15:0][W-1:0]   out4;

  bit_reverse_mapper #(.N(3), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(iv3), .in(in3), .out_valid(ov3), .out(out3)
  );

  bit_reverse_mapper #(.N(4), .W(W)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in(in4), .out_valid(ov4), .out(out4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int rev(input int i, input int n);
    int r;
    r = 0;
    for (int k = 0; k < n; k++) begin
      if (i[k]) r = r | (1 << (n - 1 - k));
    end
    return r;
  endfunction

  function automatic logic [7:0][W-1:0] map3(input logic [7:0][W-1:0] v);
    logic [7:0][W-1:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[rev(i, 3)];
    return r;
  endfunction

  wide_t             q[$];
  logic [7:0][W-1:0] hold3;
  logic              samp_v;
  wide_t             exp_out;
  bit                mon_en = 1'b0;

  // Monitor: expected valid comes from the inputs sampled at the edge, data from the queue.
  always @(posedge clk) begin
    if (mon_en) begin
      samp_v = iv3 && !rst;
      #1;
      check("out_valid", wide_t'(ov3), wide_t'(samp_v));
      if (ov3) begin
        exp_out = (q.size() != 0) ? q.pop_front() : 'x;
        check("out_data", wide_t'(out3), exp_out);
        hold3 = exp_out[255:0];
      end else begin
        check("out_hold", wide_t'(out3), wide_t'(hold3));
      end
    end
  end

  task automatic drive3(input bit v, input logic [7:0][W-1:0] d, input bit r);
    @(negedge clk);
    rst = r;
    if (r) begin
      hold3 = '0;
      q.delete();
    end
    iv3 = v;
    in3 = d;
    if (v && !r) q.push_back(wide_t'(map3(d)));
  endtask

  function automatic logic [7:0][W-1:0] rand_vec();
    logic [7:0][W-1:0] r;
    for (int i = 0; i < 8; i++) r[i] = $urandom;
    return r;
  endfunction

  logic [7:0][W-1:0]  v, c, e24;
  logic [15:0][W-1:0] e23;
  int exp23[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int exp24[8]  = '{32'hA0, 32'hA4, 32'hA2, 32'hA6, 32'hA1, 32'hA5, 32'hA3, 32'hA7};

  initial begin
    iv3 = 1'b0; in3 = '0; iv4 = 1'b0; in4 = '0;
    hold3 = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_out3", wide_t'(out3), '0);
    check("rst_ov3", wide_t'(ov3), '0);
    check("rst_out4", wide_t'(out4), '0);
    check("rst_ov4", wide_t'(ov4), '0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Release reset and present a valid vector on the same edge.
    for (int i = 0; i < 8; i++) v[i] = 32'hA0 + i;
    drive3(1'b1, v, 1'b0);
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) e24[i] = exp24[i];
    check("map_a0", wide_t'(out3), wide_t'(e24));
    check("map_a0_valid", wide_t'(ov3), 1);

    // Full-width back-to-back vectors.
    drive3(1'b1, {8{32'hFFFF_FFFF}}, 1'b0);
    drive3(1'b1, {8{32'h8000_0001}}, 1'b0);
    @(posedge clk); #2;
    check("b2b_second", wide_t'(out3), wide_t'({8{32'h8000_0001}}));
    check("b2b_valid", wide_t'(ov3), 1);

    // Idle cycles with junk on the input.
    for (int k = 0; k < 5; k++) drive3(1'b0, (k == 2) ? 'x : rand_vec(), 1'b0);

    // Reset asserted together with a valid vector discards it.
    drive3(1'b1, rand_vec(), 1'b1);
    drive3(1'b0, rand_vec(), 1'b0);

    // Streaming random vectors, then an asynchronous reset between edges.
    for (int k = 0; k < 6; k++) drive3(1'b1, rand_vec(), 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    hold3 = '0;
    q.delete();
    #1;
    check("async_out", wide_t'(out3), '0);
    check("async_valid", wide_t'(ov3), '0);
    drive3(1'b0, rand_vec(), 1'b1);
    v = rand_vec();
    drive3(1'b1, v, 1'b0);
    @(posedge clk); #2;
    check("post_rst_map", wide_t'(out3), wide_t'(map3(v)));

    // Feeding the mapped vector back in restores the original order.
    v = rand_vec();
    drive3(1'b1, v, 1'b0);
    @(posedge clk); #2;
    c = out3;
    drive3(1'b1, c, 1'b0);
    @(posedge clk); #2;
    check("involution", wide_t'(out3), wide_t'(v));
    drive3(1'b0, '0, 1'b0);

    // N=4 instance: single pulse of in[i]=i.
    @(negedge clk);
    for (int i = 0; i < 16; i++) in4[i] = i;
    iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    in4 = '1;
    for (int i = 0; i < 16; i++) e23[i] = exp23[i];
    check("n4_map", wide_t'(out4), wide_t'(e23));
    check("n4_valid", wide_t'(ov4), 1);
    @(negedge clk);
    check("n4_valid_drop", wide_t'(ov4), '0);
    check("n4_hold", wide_t'(out4), wide_t'(e23));

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
